// File: rtl/ex_stage_if.sv
// ex_stage_if -- decode-to-execute handshake bundle for ex_stage.
//   slave  : the execute stage (consumes i_*, drives o_*)
//   master : the decode/MEM side or a bench (drives i_*, consumes o_*)
// Signals:
//   i_dec_valid, i_uop, i_dec_pc, i_rs1_val, i_rs2_val : uop from decode
//   i_stall, i_flush                                   : MEM backpressure, pipeline flush
//   o_ex_valid, o_ex_pc, o_ex_result, o_ex_rd, o_ex_rd_we : registered result
//   o_redirect, o_redirect_pc                          : taken control transfer pulse
//   o_stall_to_id                                      : backpressure to decode
interface ex_stage_if;

   // alu_op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
   // br_cond: 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU
   typedef struct packed {
      logic [3:0]  alu_op;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        rd_we;
      logic        use_imm;
      logic        use_pc;
      logic        is_branch;
      logic [2:0]  br_cond;
      logic        is_jal;
      logic        is_jalr;
   } uop_t;

   logic        i_dec_valid;
   uop_t        i_uop;
   logic [31:0] i_dec_pc;
   logic [31:0] i_rs1_val;
   logic [31:0] i_rs2_val;
   logic        i_stall;
   logic        i_flush;

   logic        o_ex_valid;
   logic [31:0] o_ex_pc;
   logic [31:0] o_ex_result;
   logic [4:0]  o_ex_rd;
   logic        o_ex_rd_we;
   logic        o_redirect;
   logic [31:0] o_redirect_pc;
   logic        o_stall_to_id;

   modport slave (
      input  i_dec_valid, i_uop, i_dec_pc, i_rs1_val, i_rs2_val, i_stall, i_flush,
      output o_ex_valid, o_ex_pc, o_ex_result, o_ex_rd, o_ex_rd_we,
      output o_redirect, o_redirect_pc, o_stall_to_id
   );

   modport master (
      output i_dec_valid, i_uop, i_dec_pc, i_rs1_val, i_rs2_val, i_stall, i_flush,
      input  o_ex_valid, o_ex_pc, o_ex_result, o_ex_rd, o_ex_rd_we,
      input  o_redirect, o_redirect_pc, o_stall_to_id
   );

endinterface

// File: rtl/ex_stage.sv
// ex_stage -- single-cycle execute stage: ALU, branch resolution, redirect and squash.
// Ports:
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   ex  : ex_stage_if.slave (decode uop in, registered result / redirect out)
// A taken uop raises o_redirect for one cycle and opens a squash window of
// SQUASH_CYCLES unstalled cycles in which arriving decode uops are dropped.
module ex_stage #(
   parameter int unsigned SQUASH_CYCLES = 1,
   parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
   input logic       clk,
   input logic       rst,
   ex_stage_if.slave ex
);

   localparam logic ST_RUN    = 1'b0;
   localparam logic ST_SQUASH = 1'b1;

   localparam logic [1:0] SQ_LOAD = 2'(SQUASH_CYCLES);

   logic        state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;

   logic        valid_q, rd_we_q, redirect_q;
   logic [31:0] pc_q, result_q, redirect_pc_q;
   logic [4:0]  rd_q;

   logic [31:0] op_a, op_b, alu_res, target, link;
   logic        cond, taken, accept;

   assign op_a = ex.i_uop.use_pc  ? ex.i_dec_pc    : ex.i_rs1_val;
   assign op_b = ex.i_uop.use_imm ? ex.i_uop.imm   : ex.i_rs2_val;
   assign link = ex.i_dec_pc + 32'd4;

   always_comb begin
      alu_res = '0;
      case (ex.i_uop.alu_op)
         4'd0:    alu_res = op_a + op_b;
         4'd1:    alu_res = op_a - op_b;
         4'd2:    alu_res = op_a << op_b[4:0];
         4'd3:    alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
         4'd4:    alu_res = {31'b0, op_a < op_b};
         4'd5:    alu_res = op_a ^ op_b;
         4'd6:    alu_res = op_a >> op_b[4:0];
         4'd7:    alu_res = $signed(op_a) >>> op_b[4:0];
         4'd8:    alu_res = op_a | op_b;
         4'd9:    alu_res = op_a & op_b;
         4'd10:   alu_res = op_b;
         default: alu_res = '0;
      endcase
   end

   // Branch conditions always compare the register operands, never imm/pc.
   always_comb begin
      cond = 1'b0;
      case (ex.i_uop.br_cond)
         3'd0:    cond = ex.i_rs1_val == ex.i_rs2_val;
         3'd1:    cond = ex.i_rs1_val != ex.i_rs2_val;
         3'd4:    cond = $signed(ex.i_rs1_val) <  $signed(ex.i_rs2_val);
         3'd5:    cond = $signed(ex.i_rs1_val) >= $signed(ex.i_rs2_val);
         3'd6:    cond = ex.i_rs1_val <  ex.i_rs2_val;
         3'd7:    cond = ex.i_rs1_val >= ex.i_rs2_val;
         default: cond = 1'b0;
      endcase
   end

   assign taken  = ex.i_uop.is_jal | ex.i_uop.is_jalr | (ex.i_uop.is_branch & cond);
   assign target = ex.i_uop.is_jalr ? ((ex.i_rs1_val + ex.i_uop.imm) & ~32'h1)
                                    : (ex.i_dec_pc + ex.i_uop.imm);
   assign accept = ex.i_dec_valid & ~ex.i_stall & ~ex.i_flush & (cnt_q == 2'd0);

   // Squash window only advances on unstalled cycles; flush cancels it outright.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (ex.i_flush) begin
         state_d = ST_RUN;
         cnt_d   = 2'd0;
      end else if (!ex.i_stall) begin
         case (state_q)
            ST_RUN: begin
               if (accept && taken) begin
                  state_d = ST_SQUASH;
                  cnt_d   = SQ_LOAD;
               end
            end
            ST_SQUASH: begin
               cnt_d = cnt_q - 2'd1;
               if (cnt_q <= 2'd1) begin
                  state_d = ST_RUN;
                  cnt_d   = 2'd0;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RUN;
         cnt_q         <= 2'd0;
         valid_q       <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         pc_q          <= RESET_PC;
         result_q      <= '0;
         rd_q          <= '0;
         rd_we_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (ex.i_flush) begin
            valid_q    <= 1'b0;
            redirect_q <= 1'b0;
         end else if (ex.i_stall) begin
            // Hold the result; the redirect already fired and must not repeat.
            redirect_q <= 1'b0;
         end else begin
            valid_q    <= accept;
            redirect_q <= accept & taken;
            if (accept) begin
               pc_q     <= ex.i_dec_pc;
               result_q <= (ex.i_uop.is_jal | ex.i_uop.is_jalr) ? link : alu_res;
               rd_q     <= ex.i_uop.rd;
               rd_we_q  <= ex.i_uop.rd_we & ~ex.i_uop.is_branch;
               if (taken) redirect_pc_q <= target;
            end
         end
      end
   end

   assign ex.o_ex_valid    = valid_q;
   assign ex.o_ex_pc       = pc_q;
   assign ex.o_ex_result   = result_q;
   assign ex.o_ex_rd       = rd_q;
   assign ex.o_ex_rd_we    = rd_we_q;
   assign ex.o_redirect    = redirect_q;
   assign ex.o_redirect_pc = redirect_pc_q;
   assign ex.o_stall_to_id = ex.i_stall;

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter SQUASH_CYCLES, default 1: cycles after a redirect during which arriving decode uops are discarded (range 1-3).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: value of o_ex_pc after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_dec_valid  input  1  decode output holds a valid uop.
REQ-006 i_uop  input  uop_t  decoded micro-op; fields consumed: alu_op, imm[31:0], rd[4:0], rd_we, use_imm, use_pc, is_branch, br_cond, is_jal, is_jalr.
REQ-007 i_dec_pc  input  32  PC of i_uop.
REQ-008 i_rs1_val / i_rs2_val  input  32 each  register-file operands for i_uop.
REQ-009 i_stall  input  1  downstream (MEM) cannot accept; hold stage.
REQ-010 i_flush  input  1  external pipeline flush.
REQ-011 o_ex_valid  output  1  result register valid.
REQ-012 o_ex_pc / o_ex_result  output  32 each  PC and ALU/link result.
REQ-013 o_ex_rd / o_ex_rd_we  output  5 / 1  destination register and write enable.
REQ-014 o_redirect / o_redirect_pc  output  1 / 32  taken control transfer, new fetch PC; drives IF i_flush/i_redirect_pc and ID i_flush.
REQ-015 o_stall_to_id  output  1  backpressure to decode.

Function
REQ-016 Operand A SHALL be i_dec_pc if use_pc else i_rs1_val; operand B SHALL be imm if use_imm else i_rs2_val.
REQ-017 alu_op SHALL select ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB; shifts use B[4:0]; all arithmetic modulo 2^32, no overflow flag.
REQ-018 br_cond SHALL select BEQ, BNE, BLT, BGE (signed), BLTU, BGEU on rs1 vs rs2.
REQ-019 Taken = is_jal | is_jalr | (is_branch & condition true).
REQ-020 Target: is_jalr -> (rs1 + imm) & ~32'h1; otherwise pc + imm (wraps modulo 2^32).
REQ-021 For is_jal/is_jalr, o_ex_result SHALL be pc + 4; for is_branch, o_ex_rd_we SHALL be 0.
REQ-022 Latency: a uop accepted at edge N SHALL appear on all o_ex_* at edge N, visible in cycle N+1 (one register stage, all outputs registered).
REQ-023 Accept = i_dec_valid & ~i_stall & ~i_flush & (squash counter == 0).
REQ-024 i_stall=1 SHALL hold o_ex_valid/pc/result/rd/rd_we unchanged; o_stall_to_id SHALL equal i_stall combinationally.
REQ-025 When not stalled and no accept, o_ex_valid SHALL go 0 next cycle.
REQ-026 o_redirect SHALL be a one-cycle pulse registered together with the taken uop; it SHALL NOT repeat while that uop is held by i_stall.
REQ-027 Squash FSM: RUN -> SQUASH when a taken uop is accepted, counter loaded with SQUASH_CYCLES; in SQUASH each cycle decrements, and any i_dec_valid is dropped (not accepted, no redirect); counter 0 -> RUN.
REQ-028 A stalled cycle SHALL NOT decrement the squash counter.
REQ-029 i_flush=1 SHALL clear o_ex_valid, o_redirect and the squash counter next cycle and override a simultaneous accept or stall.
REQ-030 Back-to-back taken uops cannot both be accepted: the second always falls in SQUASH.

Reset
REQ-031 During rst=1: o_ex_valid=0, o_redirect=0, o_redirect_pc=0, o_ex_pc=RESET_PC, o_ex_result=0, o_ex_rd=0, o_ex_rd_we=0, FSM=RUN, counter=0; rst overrides stall and flush.
REQ-032 Reset asserted mid-squash SHALL return to RUN with counter 0 on the following edge.

Verification
REQ-033 ADD rs1=5, rs2=7, rd=3, valid one cycle -> next cycle o_ex_valid=1, result=12, rd=3, rd_we=1, o_redirect=0.
REQ-034 BEQ pc=0x100, imm=0x20, rs1=rs2=9 -> o_redirect=1 one cycle, redirect_pc=0x120, rd_we=0; valid uop presented next cycle is dropped (o_ex_valid=0 cycle after).
REQ-035 JALR pc=0x40, rs1=0x1001, imm=4, rd=1 -> redirect_pc=0x1004, result=0x44, rd_we=1.
REQ-036 SRA rs1=0x8000_0000, rs2=31 -> result=0xFFFF_FFFF; SUB 0-1 -> 0xFFFF_FFFF.
REQ-037 Taken BNE accepted, then i_stall=1 for 3 cycles -> o_redirect high exactly 1 cycle, o_ex_* held 3 cycles, squash counter unchanged until stall drops.
REQ-038 i_flush=1 in same cycle as taken JAL valid -> no redirect, o_ex_valid=0; rst=1 in SQUASH -> next uop after rst release accepted.
